song_reader: RTL and testbench

Consumer end of the mcu control interface. Takes play/reset_player/song from mcu, fetches note words for the selected song from the song ROM, and hands them one at a time to the note player. Returns a one-cycle song_done pulse to mcu when the song ends. Sits between mcu, song_rom and note_player in the music player top level.

---
 rtl/song_reader_if.sv | 28 ++
 rtl/song_reader.sv | 106 ++++++++++
 tb/tb_song_reader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/song_reader_if.sv
// Bundle between song_reader and its neighbours: mcu control, song ROM
// read port and note_player hand-off.
interface song_reader_if #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
);
  logic                    play;
  logic                    reset_player;
  logic [1:0]              song;
  logic                    note_done;
  logic [IDX_W+1:0]        rom_addr;
  logic [NOTE_W+DUR_W-1:0] rom_data;
  logic [NOTE_W-1:0]       note;
  logic [DUR_W-1:0]        duration;
  logic                    new_note;
  logic                    song_done;

  modport slave (
    input  play, reset_player, song, note_done, rom_data,
    output rom_addr, note, duration, new_note, song_done
  );

  modport master (
    output play, reset_player, song, note_done, rom_data,
    input  rom_addr, note, duration, new_note, song_done
  );
endinterface

// File: rtl/song_reader.sv
// Walks the selected song in ROM one note at a time, handing each note to the
// note player and pulsing song_done at an end marker or after the last slot.
module song_reader #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int IDX_W  = 5
) (
  input logic          clk,
  input logic          reset,
  song_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAYING} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [NOTE_W-1:0] note_reg, note_next;
  logic [DUR_W-1:0]  dur_reg, dur_next;
  logic              new_note_reg, new_note_next;
  logic              song_done_reg, song_done_next;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = bus.rom_data[DUR_W-1:0];

  // The address follows song directly, so a song change lands on the next fetch.
  assign bus.rom_addr  = {bus.song, idx_reg};
  assign bus.note      = note_reg;
  assign bus.duration  = dur_reg;
  assign bus.new_note  = new_note_reg;
  assign bus.song_done = song_done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      note_reg      <= '0;
      dur_reg       <= '0;
      new_note_reg  <= 1'b0;
      song_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      note_reg      <= note_next;
      dur_reg       <= dur_next;
      new_note_reg  <= new_note_next;
      song_done_reg <= song_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    note_next      = note_reg;
    dur_next       = dur_reg;
    new_note_next  = 1'b0;
    song_done_next = 1'b0;

    if (bus.reset_player) begin
      state_next = IDLE;
      idx_next   = '0;
      note_next  = '0;
      dur_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.play) state_next = FETCH;
        end
        FETCH: begin
          state_next = WAIT;
        end
        WAIT: begin
          // A zero duration marks the end of a song shorter than the full table.
          if (rom_dur == '0) begin
            song_done_next = 1'b1;
            idx_next       = '0;
            state_next     = IDLE;
          end else begin
            note_next     = rom_note;
            dur_next      = rom_dur;
            new_note_next = 1'b1;
            state_next    = PLAYING;
          end
        end
        PLAYING: begin
          if (bus.note_done) begin
            if (idx_reg == LAST_IDX) begin
              song_done_next = 1'b1;
              idx_next       = '0;
              state_next     = IDLE;
            end else begin
              idx_next   = idx_reg + 1'b1;
              state_next = bus.play ? FETCH : IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Randomised scoreboard bench for song_reader: a song-level model predicts the
// note/song_done sequence and a negedge monitor checks every DUT output pulse.
module tb_song_reader;

  logic clk;
  logic reset;

  song_reader_if #(.NOTE_W(6), .DUR_W(6), .IDX_W(5)) bif ();

  song_reader #(.NOTE_W(6), .DUR_W(6), .IDX_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] rom [128];

  always @(posedge clk) bif.rom_data <= rom[bif.rom_addr];

  typedef struct {
    bit         done;
    logic [5:0] note;
    logic [5:0] dur;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Song-level model: notes in table order until a zero duration or the 32nd slot.
  function automatic void build_expect(input int s, input bit prio);
    logic [11:0] w;
    exp_t e;
    for (int i = 0; i < 32; i++) begin
      w = rom[s*32 + i];
      if (w[5:0] == 6'd0) begin
        e.done = 1'b1; e.note = '0; e.dur = '0;
        exp_q.push_back(e);
        return;
      end
      e.done = 1'b0; e.note = w[11:6]; e.dur = w[5:0];
      exp_q.push_back(e);
      if (prio && i == 31) return;
    end
    e.done = 1'b1; e.note = '0; e.dur = '0;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bif.new_note || bif.song_done) begin
      check("pulse_exclusive", 32'(bif.new_note & bif.song_done), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'({bif.new_note, bif.song_done}), 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 32'(bif.song_done), 32'(e.done));
        if (!e.done) begin
          check("note", 32'(bif.note), 32'(e.note));
          check("duration", 32'(bif.duration), 32'(e.dur));
          $display("txn new_note note=%0d dur=%0d", bif.note, bif.duration);
        end else begin
          $display("txn song_done");
        end
      end
    end
  end

  // Counts edges until a pulse appears; note_done is a single-cycle pulse.
  task automatic measure(output int lat, output int kind);
    lat = 0;
    kind = 0;
    while (kind == 0 && lat < 12) begin
      @(posedge clk); #1;
      bif.note_done = 1'b0;
      lat++;
      if (bif.new_note) kind = 1;
      else if (bif.song_done) kind = 2;
    end
  endtask

  task automatic fill_song(input int s, input int marker_odds);
    logic [5:0] d;
    for (int i = 0; i < 32; i++) begin
      d = 6'($urandom_range(1, 63));
      if (marker_odds > 0 && $urandom_range(0, marker_odds - 1) == 0) d = 6'd0;
      rom[s*32 + i] = {6'($urandom_range(0, 63)), d};
    end
  endtask

  task automatic run_song(input int s, input int pause_idx, input bit prio);
    int idx, lat, kind;
    build_expect(s, prio);
    bif.song = 2'(s);
    bif.reset_player = 1'b1;
    @(posedge clk); #1;
    bif.reset_player = 1'b0;
    bif.play = 1'b1;
    measure(lat, kind);
    check("start_latency", lat, 3);
    idx = 0;
    while (kind == 1) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (prio && idx == 31) begin
        bif.reset_player = 1'b1;
        bif.note_done    = 1'b1;
        bif.play         = 1'b0;
        @(posedge clk); #1;
        bif.reset_player = 1'b0;
        bif.note_done    = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("prio_addr", 32'(bif.rom_addr), s*32);
        kind = 3;
      end else if (idx == pause_idx) begin
        bif.play      = 1'b0;
        bif.note_done = 1'b1;
        measure(lat, kind);
        check("pause_quiet", kind, 0);
        check("pause_addr", 32'(bif.rom_addr), s*32 + idx + 1);
        bif.play = 1'b1;
        measure(lat, kind);
        check("resume_latency", lat, 3);
      end else begin
        bif.note_done = 1'b1;
        measure(lat, kind);
        check("next_latency", lat, (idx == 31) ? 1 : 3);
      end
      idx++;
    end
    bif.play = 1'b0;
    check("end_kind", kind, prio ? 3 : 2);
    @(posedge clk); #1;
    if (kind == 2) check("end_addr", 32'(bif.rom_addr), s*32);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int lat, kind, s;
    exp_t e;
    for (int i = 0; i < 128; i++) rom[i] = 12'h041;
    reset = 1'b0;
    bif.play = 1'b0;
    bif.reset_player = 1'b0;
    bif.song = 2'd1;
    bif.note_done = 1'b0;
    #2;
    check("rst_new_note", 32'(bif.new_note), 0);
    check("rst_song_done", 32'(bif.song_done), 0);
    check("rst_note", 32'(bif.note), 0);
    check("rst_duration", 32'(bif.duration), 0);
    check("rst_addr", 32'(bif.rom_addr), 32);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    // Basic fetch and end marker on song 2.
    fill_song(2, 0);
    rom[64] = {6'd5, 6'd10};
    rom[66] = {6'd9, 6'd0};
    run_song(2, -1, 1'b0);

    // Full 32-note song.
    fill_song(3, 0);
    run_song(3, -1, 1'b0);

    // Pause at idx 4.
    fill_song(1, 0);
    run_song(1, 4, 1'b0);

    // reset_player wins over note_done on the last note.
    fill_song(3, 0);
    run_song(3, -1, 1'b1);

    // Randomised songs with occasional end markers and pauses.
    for (int t = 0; t < 6; t++) begin
      s = $urandom_range(0, 3);
      fill_song(s, 12);
      run_song(s, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1, 1'b0);
    end

    // Asynchronous reset while a note is playing.
    rom[0] = {6'd7, 6'd9};
    bif.song = 2'd0;
    bif.reset_player = 1'b1;
    @(posedge clk); #1;
    bif.reset_player = 1'b0;
    e.done = 1'b0; e.note = 6'd7; e.dur = 6'd9;
    exp_q.push_back(e);
    bif.play = 1'b1;
    measure(lat, kind);
    check("async_pre_latency", lat, 3);
    #2;
    reset = 1'b0;
    #1;
    check("async_new_note", 32'(bif.new_note), 0);
    check("async_note", 32'(bif.note), 0);
    check("async_duration", 32'(bif.duration), 0);
    check("async_addr", 32'(bif.rom_addr), 0);
    exp_q.delete();
    bif.play = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    check("async_idle_new_note", 32'(bif.new_note), 0);
    check("async_idle_addr", 32'(bif.rom_addr), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
